// File: rtl/l2_arb_pkg.sv
// Shared types and constants for the L2 request-port arbiter.
// The request struct is the payload in the default 32/32/2 configuration.
package l2_arb_pkg;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    localparam int unsigned DEF_ADDR_WIDTH  = 32;
    localparam int unsigned DEF_DATA_WIDTH  = 32;
    localparam int unsigned DEF_REQ_ID_BITS = 2;

    // L2-side tag carries one extra requester-select bit above the L1 tag
    function automatic int unsigned l2_id_width(input int unsigned req_id_bits);
        return req_id_bits + 1;
    endfunction

    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0]  addr;
        logic [DEF_DATA_WIDTH-1:0]  data;
        logic                       rw;
        logic [DEF_REQ_ID_BITS:0]   id;
    } l2_req_t;

endpackage

// File: rtl/outst_credit_cnt.sv
// Saturating up/down counter of outstanding reads for one requester.
module outst_credit_cnt #(
    parameter int unsigned CNT_BITS  = 3,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    output logic full
);

    logic [CNT_BITS-1:0] cnt_q, cnt_d;

    // Simultaneous inc/dec nets to zero; stray decrements stop at 0
    always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec) begin
            cnt_d = cnt_q + CNT_BITS'(1);
        end else if (dec && !inc && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign full = (cnt_q >= CNT_BITS'(MAX_OUTST));

endmodule

// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing the L2 request port between I-side and D-side
// L1 miss paths, with response demux and per-port read credit limits.
module l2_port_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned REQ_ID_BITS = 2,
    parameter int unsigned MAX_OUTST   = 4,
    parameter int unsigned CNT_BITS    = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_WIDTH-1:0]  p0_addr_in,
    input  logic [DATA_WIDTH-1:0]  p0_data_in,
    input  logic                   p0_rw_in,
    input  logic                   p0_valid_in,
    input  logic [REQ_ID_BITS-1:0] p0_id_in,
    output logic                   p0_stall_out,
    output logic [DATA_WIDTH-1:0]  p0_data_out,
    output logic [REQ_ID_BITS-1:0] p0_id_out,
    output logic                   p0_ready_out,
    input  logic [ADDR_WIDTH-1:0]  p1_addr_in,
    input  logic [DATA_WIDTH-1:0]  p1_data_in,
    input  logic                   p1_rw_in,
    input  logic                   p1_valid_in,
    input  logic [REQ_ID_BITS-1:0] p1_id_in,
    output logic                   p1_stall_out,
    output logic [DATA_WIDTH-1:0]  p1_data_out,
    output logic [REQ_ID_BITS-1:0] p1_id_out,
    output logic                   p1_ready_out,
    output logic [ADDR_WIDTH-1:0]  l2_addr_out,
    output logic [DATA_WIDTH-1:0]  l2_data_out,
    output logic                   l2_rw_out,
    output logic                   l2_valid_out,
    output logic [REQ_ID_BITS:0]   l2_id_out,
    input  logic                   l2_stall_in,
    input  logic [DATA_WIDTH-1:0]  l2_data_in,
    input  logic [REQ_ID_BITS:0]   l2_id_in,
    input  logic                   l2_ready_in
);

    import l2_arb_pkg::*;

    localparam int unsigned L2_ID_BITS = l2_id_width(REQ_ID_BITS);

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic                  rw;
        logic [L2_ID_BITS-1:0] id;
    } oreg_t;

    oreg_t oreg_q, oreg_d;
    logic  last_q, last_d;
    logic  full0, full1;
    logic  elig0, elig1, grant0, grant1, acc0, acc1;
    logic  l2_acc, can_load;
    logic  rsp0, rsp1;

    assign rsp0 = l2_ready_in & (l2_id_in[L2_ID_BITS-1] == REQ_I);
    assign rsp1 = l2_ready_in & (l2_id_in[L2_ID_BITS-1] == REQ_D);

    outst_credit_cnt #(.CNT_BITS(CNT_BITS), .MAX_OUTST(MAX_OUTST)) u_cnt0 (
        .clk   (clk),
        .reset (reset),
        .inc   (acc0 & ~p0_rw_in),
        .dec   (rsp0),
        .full  (full0)
    );

    outst_credit_cnt #(.CNT_BITS(CNT_BITS), .MAX_OUTST(MAX_OUTST)) u_cnt1 (
        .clk   (clk),
        .reset (reset),
        .inc   (acc1 & ~p1_rw_in),
        .dec   (rsp1),
        .full  (full1)
    );

    // Grant, acceptance and output-register next state
    always_comb begin
        l2_acc   = oreg_q.valid & ~l2_stall_in;
        can_load = ~oreg_q.valid | l2_acc;
        elig0    = ~reset & p0_valid_in & (p0_rw_in | ~full0);
        elig1    = ~reset & p1_valid_in & (p1_rw_in | ~full1);
        grant0   = elig0 & (~elig1 | (last_q == REQ_D));
        grant1   = elig1 & (~elig0 | (last_q == REQ_I));
        acc0     = grant0 & can_load;
        acc1     = grant1 & can_load;
        oreg_d   = oreg_q;
        last_d   = last_q;
        if (l2_acc) begin
            oreg_d.valid = 1'b0;
        end
        if (acc0) begin
            oreg_d = '{valid: 1'b1, addr: p0_addr_in, data: p0_data_in,
                       rw: p0_rw_in, id: {REQ_I, p0_id_in}};
            last_d = REQ_I;
        end else if (acc1) begin
            oreg_d = '{valid: 1'b1, addr: p1_addr_in, data: p1_data_in,
                       rw: p1_rw_in, id: {REQ_D, p1_id_in}};
            last_d = REQ_D;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            oreg_q <= '0;
            last_q <= REQ_D;
        end else begin
            oreg_q <= oreg_d;
            last_q <= last_d;
        end
    end

    assign p0_stall_out = ~acc0;
    assign p1_stall_out = ~acc1;

    assign l2_valid_out = oreg_q.valid;
    assign l2_addr_out  = oreg_q.addr;
    assign l2_data_out  = oreg_q.data;
    assign l2_rw_out    = oreg_q.rw;
    assign l2_id_out    = oreg_q.id;

    // Zero-latency response demux; data fans out to both ports
    assign p0_ready_out = rsp0;
    assign p1_ready_out = rsp1;
    assign p0_id_out    = l2_id_in[REQ_ID_BITS-1:0];
    assign p1_id_out    = l2_id_in[REQ_ID_BITS-1:0];
    assign p0_data_out  = l2_data_in;
    assign p1_data_out  = l2_data_in;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Self-checking bench for l2_port_arbiter: directed sequences, a response
// routing table and a randomized phase against a behavioural model.
module tb_l2_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned RB = 2;
    localparam int unsigned MO = 4;
    localparam int unsigned CB = 3;
    localparam int unsigned LW = RB + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] p0_addr_in, p1_addr_in, l2_addr_out;
    logic [DW-1:0] p0_data_in, p1_data_in, p0_data_out, p1_data_out;
    logic [DW-1:0] l2_data_out, l2_data_in;
    logic          p0_rw_in, p1_rw_in, p0_valid_in, p1_valid_in;
    logic [RB-1:0] p0_id_in, p1_id_in, p0_id_out, p1_id_out;
    logic          p0_stall_out, p1_stall_out, p0_ready_out, p1_ready_out;
    logic          l2_rw_out, l2_valid_out, l2_stall_in, l2_ready_in;
    logic [LW-1:0] l2_id_out, l2_id_in;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    bit            m_valid;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    bit            m_rw;
    logic [LW-1:0] m_id;
    int            mcnt [2];
    int            mlast;
    bit            m_acc_prev [2];

    l2_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REQ_ID_BITS(RB),
                      .MAX_OUTST(MO), .CNT_BITS(CB)) dut (
        .clk(clk), .reset(reset),
        .p0_addr_in(p0_addr_in), .p0_data_in(p0_data_in), .p0_rw_in(p0_rw_in),
        .p0_valid_in(p0_valid_in), .p0_id_in(p0_id_in), .p0_stall_out(p0_stall_out),
        .p0_data_out(p0_data_out), .p0_id_out(p0_id_out), .p0_ready_out(p0_ready_out),
        .p1_addr_in(p1_addr_in), .p1_data_in(p1_data_in), .p1_rw_in(p1_rw_in),
        .p1_valid_in(p1_valid_in), .p1_id_in(p1_id_in), .p1_stall_out(p1_stall_out),
        .p1_data_out(p1_data_out), .p1_id_out(p1_id_out), .p1_ready_out(p1_ready_out),
        .l2_addr_out(l2_addr_out), .l2_data_out(l2_data_out), .l2_rw_out(l2_rw_out),
        .l2_valid_out(l2_valid_out), .l2_id_out(l2_id_out), .l2_stall_in(l2_stall_in),
        .l2_data_in(l2_data_in), .l2_id_in(l2_id_in), .l2_ready_in(l2_ready_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_elig(input int n);
        bit v, rw;
        v  = (n == 0) ? p0_valid_in : p1_valid_in;
        rw = (n == 0) ? p0_rw_in : p1_rw_in;
        if (reset) return 1'b0;
        return v && (rw || mcnt[n] < int'(MO));
    endfunction

    function automatic bit m_acc(input int n);
        bit e0, e1;
        int w;
        e0 = m_elig(0);
        e1 = m_elig(1);
        if (m_valid && l2_stall_in) return 1'b0;
        if (e0 && e1)  w = 1 - mlast;
        else if (e0)   w = 0;
        else if (e1)   w = 1;
        else           return 1'b0;
        return w == n;
    endfunction

    // Advance the model across one rising edge using the pre-edge inputs
    task automatic model_edge();
        bit a [2];
        bit inc, dec;
        a[0] = m_acc(0);
        a[1] = m_acc(1);
        m_acc_prev = a;
        if (reset) begin
            m_valid = 0; m_addr = '0; m_data = '0; m_rw = 0; m_id = '0;
            mcnt[0] = 0; mcnt[1] = 0; mlast = 1;
            return;
        end
        for (int n = 0; n < 2; n++) begin
            inc = a[n] && !((n == 0) ? p0_rw_in : p1_rw_in);
            dec = l2_ready_in && (int'(l2_id_in[LW-1]) == n);
            if (inc && !dec) mcnt[n]++;
            else if (dec && !inc && mcnt[n] > 0) mcnt[n]--;
        end
        if (a[0]) begin
            m_valid = 1; m_addr = p0_addr_in; m_data = p0_data_in; m_rw = p0_rw_in;
            m_id = {1'b0, p0_id_in}; mlast = 0;
        end else if (a[1]) begin
            m_valid = 1; m_addr = p1_addr_in; m_data = p1_data_in; m_rw = p1_rw_in;
            m_id = {1'b1, p1_id_in}; mlast = 1;
        end else if (m_valid && !l2_stall_in) begin
            m_valid = 0;
        end
    endtask

    task automatic model_check();
        chk("rnd_stall0", 64'(p0_stall_out), 64'(!m_acc(0)));
        chk("rnd_stall1", 64'(p1_stall_out), 64'(!m_acc(1)));
        chk("rnd_l2_valid", 64'(l2_valid_out), 64'(m_valid));
        if (m_valid) begin
            chk("rnd_l2_addr", 64'(l2_addr_out), 64'(m_addr));
            chk("rnd_l2_data", 64'(l2_data_out), 64'(m_data));
            chk("rnd_l2_rw", 64'(l2_rw_out), 64'(m_rw));
            chk("rnd_l2_id", 64'(l2_id_out), 64'(m_id));
        end
        chk("rnd_ready0", 64'(p0_ready_out), 64'(l2_ready_in && l2_id_in[LW-1] == 1'b0));
        chk("rnd_ready1", 64'(p1_ready_out), 64'(l2_ready_in && l2_id_in[LW-1] == 1'b1));
        chk("rnd_id0", 64'(p0_id_out), 64'(l2_id_in[RB-1:0]));
        chk("rnd_data1", 64'(p1_data_out), 64'(l2_data_in));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        p0_valid_in = 0; p0_rw_in = 0; p0_addr_in = '0; p0_data_in = '0; p0_id_in = '0;
        p1_valid_in = 0; p1_rw_in = 0; p1_addr_in = '0; p1_data_in = '0; p1_id_in = '0;
        l2_stall_in = 0; l2_ready_in = 0; l2_id_in = '0; l2_data_in = '0;
    endtask

    task automatic do_reset();
        reset = 1;
        idle();
        tick();
        reset = 0;
    endtask

    task automatic set_p0(input bit v, input bit rw, input logic [AW-1:0] a, input logic [RB-1:0] id);
        p0_valid_in = v; p0_rw_in = rw; p0_addr_in = a; p0_data_in = ~a; p0_id_in = id;
    endtask

    task automatic set_p1(input bit v, input bit rw, input logic [AW-1:0] a, input logic [RB-1:0] id);
        p1_valid_in = v; p1_rw_in = rw; p1_addr_in = a; p1_data_in = ~a; p1_id_in = id;
    endtask

    task automatic rand_req(output logic v, output logic rw, output logic [AW-1:0] a,
                            output logic [DW-1:0] d, output logic [RB-1:0] id);
        v  = ($urandom_range(0, 1) == 1);
        rw = ($urandom_range(0, 2) == 0);
        a  = AW'($urandom);
        d  = DW'($urandom);
        id = RB'($urandom);
    endtask

    typedef struct {
        logic          rdy;
        logic [LW-1:0] id;
        logic [DW-1:0] data;
        logic          e_r0;
        logic          e_r1;
        logic [RB-1:0] e_id;
    } rsp_vec_t;

    rsp_vec_t tbl [6];

    initial begin
        tbl[0] = '{1'b1, 3'b001, 32'hDEADBEEF, 1'b1, 1'b0, 2'b01};
        tbl[1] = '{1'b1, 3'b110, 32'h12345678, 1'b0, 1'b1, 2'b10};
        tbl[2] = '{1'b0, 3'b101, 32'hCAFEF00D, 1'b0, 1'b0, 2'b01};
        tbl[3] = '{1'b1, 3'b000, 32'h00000000, 1'b1, 1'b0, 2'b00};
        tbl[4] = '{1'b1, 3'b111, 32'hFFFFFFFF, 1'b0, 1'b1, 2'b11};
        tbl[5] = '{1'b0, 3'b011, 32'hA5A5A5A5, 1'b0, 1'b0, 2'b11};

        reset = 1;
        idle();
        mcnt[0] = 0; mcnt[1] = 0; mlast = 1; m_valid = 0;
        m_addr = '0; m_data = '0; m_rw = 0; m_id = '0;
        m_acc_prev[0] = 0; m_acc_prev[1] = 0;
        tick();

        // Reset state: no acceptance, outputs cleared, responses still routed
        set_p0(1, 0, 32'h40, 2'd1);
        set_p1(1, 1, 32'h80, 2'd2);
        l2_ready_in = 1; l2_id_in = 3'b010;
        @(negedge clk);
        chk("rst_stall0", 64'(p0_stall_out), 64'(1));
        chk("rst_stall1", 64'(p1_stall_out), 64'(1));
        chk("rst_l2_valid", 64'(l2_valid_out), 64'(0));
        chk("rst_l2_addr", 64'(l2_addr_out), 64'(0));
        chk("rst_l2_id", 64'(l2_id_out), 64'(0));
        chk("rst_ready0", 64'(p0_ready_out), 64'(1));
        tick();

        // First read after reset: one-cycle latency to L2
        reset = 0;
        idle();
        set_p0(1, 0, 32'h100, 2'd2);
        @(negedge clk);
        chk("first_stall0", 64'(p0_stall_out), 64'(0));
        chk("first_stall1", 64'(p1_stall_out), 64'(1));
        tick();
        idle();
        @(negedge clk);
        chk("first_l2_valid", 64'(l2_valid_out), 64'(1));
        chk("first_l2_addr", 64'(l2_addr_out), 64'(32'h100));
        chk("first_l2_id", 64'(l2_id_out), 64'(3'b010));
        chk("first_l2_rw", 64'(l2_rw_out), 64'(0));
        tick();

        // Round-robin alternation with both ports requesting
        do_reset();
        for (int k = 0; k < 5; k++) begin
            if (k < 4) begin
                set_p0(1, 0, AW'(32'h200 + k), RB'(k));
                set_p1(1, 0, AW'(32'h300 + k), RB'(k));
            end else begin
                idle();
            end
            @(negedge clk);
            if (k < 4) begin
                chk("rr_stall0", 64'(p0_stall_out), 64'(k % 2));
                chk("rr_stall1", 64'(p1_stall_out), 64'(1 - k % 2));
            end
            if (k > 0) begin
                chk("rr_l2_valid", 64'(l2_valid_out), 64'(1));
                chk("rr_l2_id_msb", 64'(l2_id_out[LW-1]), 64'((k - 1) % 2));
            end
            tick();
        end

        // L2 stall holds oreg and stalls both ports
        do_reset();
        set_p0(1, 1, 32'hA0, 2'd0);
        @(negedge clk);
        chk("stl_load", 64'(p0_stall_out), 64'(0));
        tick();
        set_p0(1, 0, 32'hB0, 2'd1);
        set_p1(1, 1, 32'hC0, 2'd3);
        l2_stall_in = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stl_stall0", 64'(p0_stall_out), 64'(1));
            chk("stl_stall1", 64'(p1_stall_out), 64'(1));
            chk("stl_l2_addr", 64'(l2_addr_out), 64'(32'hA0));
            chk("stl_l2_valid", 64'(l2_valid_out), 64'(1));
            tick();
        end
        l2_stall_in = 0;
        @(negedge clk);
        chk("stl_rel_stall1", 64'(p1_stall_out), 64'(0));
        chk("stl_rel_stall0", 64'(p0_stall_out), 64'(1));
        tick();
        p1_valid_in = 0;
        @(negedge clk);
        chk("stl_next_addr", 64'(l2_addr_out), 64'(32'hC0));
        chk("stl_next_id", 64'(l2_id_out), 64'(3'b111));
        chk("stl_next_p0", 64'(p0_stall_out), 64'(0));
        tick();

        // Credit exhaustion on the D-side stalls reads but not writes
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_p1(1, 0, AW'(32'h400 + k), RB'(k));
            @(negedge clk);
            chk("cr_read_acc", 64'(p1_stall_out), 64'(0));
            tick();
        end
        set_p1(1, 0, 32'h500, 2'd0);
        @(negedge clk);
        chk("cr_full_stall", 64'(p1_stall_out), 64'(1));
        tick();
        set_p1(1, 1, 32'h600, 2'd1);
        @(negedge clk);
        chk("cr_write_acc", 64'(p1_stall_out), 64'(0));
        tick();
        set_p1(1, 0, 32'h500, 2'd0);
        l2_ready_in = 1; l2_id_in = 3'b110; l2_data_in = 32'h0BADF00D;
        @(negedge clk);
        chk("cr_rsp_ready1", 64'(p1_ready_out), 64'(1));
        chk("cr_rsp_ready0", 64'(p0_ready_out), 64'(0));
        chk("cr_rsp_id1", 64'(p1_id_out), 64'(2'b10));
        chk("cr_rsp_stall", 64'(p1_stall_out), 64'(1));
        tick();
        l2_ready_in = 0;
        @(negedge clk);
        chk("cr_freed_acc", 64'(p1_stall_out), 64'(0));
        tick();
        idle();

        // Response routing table
        for (int i = 0; i < 6; i++) begin
            l2_ready_in = tbl[i].rdy; l2_id_in = tbl[i].id; l2_data_in = tbl[i].data;
            @(negedge clk);
            chk("tbl_ready0", 64'(p0_ready_out), 64'(tbl[i].e_r0));
            chk("tbl_ready1", 64'(p1_ready_out), 64'(tbl[i].e_r1));
            chk("tbl_id0", 64'(p0_id_out), 64'(tbl[i].e_id));
            chk("tbl_id1", 64'(p1_id_out), 64'(tbl[i].e_id));
            chk("tbl_data0", 64'(p0_data_out), 64'(tbl[i].data));
            chk("tbl_data1", 64'(p1_data_out), 64'(tbl[i].data));
            tick();
        end
        idle();

        // Mid-stream reset clears oreg and credits; late response saturates
        do_reset();
        for (int k = 0; k < 2; k++) begin
            set_p0(1, 0, AW'(32'h700 + k), RB'(k));
            @(negedge clk);
            chk("mr_pre_acc", 64'(p0_stall_out), 64'(0));
            tick();
        end
        set_p0(1, 0, 32'h780, 2'd2);
        l2_stall_in = 1;
        reset = 1;
        @(negedge clk);
        chk("mr_rst_stall0", 64'(p0_stall_out), 64'(1));
        tick();
        reset = 0;
        idle();
        l2_ready_in = 1; l2_id_in = 3'b011;
        @(negedge clk);
        chk("mr_l2_valid", 64'(l2_valid_out), 64'(0));
        chk("mr_late_ready0", 64'(p0_ready_out), 64'(1));
        chk("mr_late_id0", 64'(p0_id_out), 64'(3));
        tick();
        l2_ready_in = 0;
        for (int k = 0; k < 5; k++) begin
            set_p0(1, 0, AW'(32'h800 + k), RB'(k));
            @(negedge clk);
            chk("mr_credit", 64'(p0_stall_out), 64'(k == 4 ? 1 : 0));
            tick();
        end
        idle();

        // Randomized phase against the model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (!p0_valid_in || m_acc_prev[0])
                rand_req(p0_valid_in, p0_rw_in, p0_addr_in, p0_data_in, p0_id_in);
            if (!p1_valid_in || m_acc_prev[1])
                rand_req(p1_valid_in, p1_rw_in, p1_addr_in, p1_data_in, p1_id_in);
            l2_stall_in = ($urandom_range(0, 3) == 0);
            l2_ready_in = ($urandom_range(0, 2) == 0);
            l2_id_in    = LW'($urandom);
            l2_data_in  = DW'($urandom);
            reset       = ($urandom_range(0, 99) == 0);
            @(negedge clk);
            model_check();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
